seg_capture: RTL
================

SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical input samples required before a pattern is accepted; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 cathode  input  7  active-low segment bus; bit0 = segment a … bit6 = segment g.
REQ-005 AN  input  8  active-low digit enables; exactly one low bit selects a digit position.
REQ-006 err_clr  input  1  clears the sticky err flag.
REQ-007 digits  output  32  captured BCD values; digit i at bits [4i+3:4i].
REQ-008 digit_valid  output  8  bit i set once digit i holds a captured value.
REQ-009 update  output  1  one-cycle pulse in the same cycle a digits/digit_valid write becomes visible.
REQ-010 err  output  1  sticky flag for an illegal pattern or an illegal AN code.

Function
REQ-011 {AN, cathode} shall be registered once on entry; all further logic shall use only the registered copy.
REQ-012 A stability counter shall increment while the registered sample equals the previous registered sample, reset to 0 on any difference, and saturate at STABLE_CYCLES-1.
REQ-013 An accept event shall fire exactly once, on the cycle the counter first reaches STABLE_CYCLES-1; it shall not refire while the pattern remains stable.
REQ-014 Input-to-output latency shall be STABLE_CYCLES+1 clock edges from the first edge that samples a new stable value to digits reflecting it.
REQ-015 Decode table (cathode -> BCD): 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0011000->9.
REQ-016 On accept with one-hot-low AN and a table pattern, digits[i] shall be written, digit_valid[i] set, and update pulsed; this applies even if the value is unchanged.
REQ-017 On accept with one-hot-low AN and a non-table pattern, err shall be set and no digit written.
REQ-018 On accept with AN = 8'hFF, nothing shall be written and err shall not change.
REQ-019 On accept with two or more AN bits low, err shall be set and no digit written.
REQ-020 If err_clr and an err-setting event occur in the same cycle, err shall be 1 (set wins).
REQ-021 digits for positions never written shall hold 4'h0.

Reset
REQ-022 While reset is high at a clock edge: digits = 0, digit_valid = 0, update = 0, err = 0, stability counter = 0, input register = {8'hFF, 7'h7F}.
REQ-023 Reset asserted mid-window shall discard the partial stability count; after release, a full STABLE_CYCLES window is required before the next accept.

Configuration
REQ-024 Macro SEG_CAPTURE_BLANK_EN: when defined, an accepted pattern 1111111 with one-hot-low AN shall clear digit_valid[i], leave digits[i] unchanged, pulse update, and not set err.
REQ-025 When SEG_CAPTURE_BLANK_EN is undefined, pattern 1111111 shall be treated as a non-table pattern per REQ-017.

Structure
REQ-026 Package seg_pkg shall hold the ten segment pattern constants, SEG_BLANK (7'b1111111), and the STABLE_CYCLES default.
REQ-027 Combinational lookup sub-module seg_pattern_to_bcd (cathode in; 4-bit BCD and a hit flag out) shall implement REQ-015 and shall be instantiated once.

Verification
REQ-028 AN = 8'b11111110, cathode = 0100100, held for 10 cycles -> digits[3:0] = 2 and digit_valid[0] = 1 at edge 5; update pulses once.
REQ-029 Scan 0..7 through positions 0..7, each held 6 cycles -> digits = 32'h76543210, digit_valid = 8'hFF, 8 update pulses.
REQ-030 Pattern toggles every 2 cycles (shorter than STABLE_CYCLES) -> no update and no err.
REQ-031 AN = 8'b11110011 stable -> err = 1; err_clr pulse in the same cycle as a new error -> err remains 1; err_clr alone -> err = 0.
REQ-032 cathode = 1111111 on position 2 with digit_valid[2] = 1 -> with the macro: digit_valid[2] = 0 and err = 0; without it: err = 1 and digit_valid[2] = 1.
REQ-033 Reset asserted at count 2 of a valid window -> all outputs 0; accept occurs only after a full new window.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment capture block.
//   - Active-low segment patterns for digits 0..9 (bit0 = segment a ... bit6 = segment g)
//   - SEG_BLANK, the all-segments-off pattern
//   - Idle values loaded into the input register on reset
//   - Default stability window length
//   - Helper that returns the position of the low bit in an active-low digit enable
package seg_pkg;

  localparam int unsigned STABLE_CYCLES_DEF = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [7:0] AN_IDLE   = 8'hFF;
  localparam logic [6:0] CATH_IDLE = 7'h7F;

  // Index of a low bit in an active-low enable. Meaningful only when
  // exactly one bit is low; callers qualify it with a one-hot check.
  function automatic logic [2:0] low_pos(input logic [7:0] an);
    logic [2:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) p = 3'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// seg_pattern_to_bcd: combinational seven-segment pattern to BCD lookup.
// Ports:
//   cathode_i [6:0]  active-low segment pattern (bit0 = a ... bit6 = g)
//   bcd_o     [3:0]  decoded digit, 0 when the pattern is not a digit
//   hit_o            1 when the pattern is one of the ten digit patterns
module seg_pattern_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] cathode_i,
  output logic [3:0] bcd_o,
  output logic       hit_o
);

  always_comb begin
    bcd_o = 4'd0;
    hit_o = 1'b1;
    case (cathode_i)
      SEG_0:   bcd_o = 4'd0;
      SEG_1:   bcd_o = 4'd1;
      SEG_2:   bcd_o = 4'd2;
      SEG_3:   bcd_o = 4'd3;
      SEG_4:   bcd_o = 4'd4;
      SEG_5:   bcd_o = 4'd5;
      SEG_6:   bcd_o = 4'd6;
      SEG_7:   bcd_o = 4'd7;
      SEG_8:   bcd_o = 4'd8;
      SEG_9:   bcd_o = 4'd9;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_capture.sv
// seg_capture: watches a multiplexed seven-segment display bus and captures
// the BCD value shown on each of eight digit positions once the bus has been
// stable for STABLE_CYCLES consecutive samples.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   cathode [6:0]       active-low segment bus (bit0 = a ... bit6 = g)
//   AN      [7:0]       active-low digit enables
//   err_clr             clears the sticky err flag (a simultaneous new error wins)
//   digits  [31:0]      captured BCD, digit i at [4i+3:4i]
//   digit_valid [7:0]   bit i set once digit i has been captured
//   update              one-cycle pulse when digits/digit_valid change
//   err                 sticky: illegal segment pattern or multiple enables low
// Build option: define SEG_CAPTURE_BLANK_EN to make an accepted all-off
// pattern on a single position invalidate that digit instead of flagging err.
module seg_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  cathode,
  input  logic [7:0]  AN,
  input  logic        err_clr,
  output logic [31:0] digits,
  output logic [7:0]  digit_valid,
  output logic        update,
  output logic        err
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  // Output write lands on the same edge the counter reaches CNT_MAX,
  // so the decision is taken while the counter still reads one less.
  localparam logic [7:0] CNT_ACC = 8'(STABLE_CYCLES - 2);

  logic [14:0] samp_q, prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  valid_q, valid_d;
  logic        update_q, update_d;
  logic        err_q, err_d;

  logic [7:0]  samp_an;
  logic [6:0]  samp_cath;
  logic        stable, accept, one_hot, none_sel, hit, err_set;
  logic [2:0]  pos;
  logic [3:0]  bcd;

  assign samp_an   = samp_q[14:7];
  assign samp_cath = samp_q[6:0];
  assign stable    = (samp_q == prev_q);
  assign accept    = stable && (cnt_q == CNT_ACC);
  assign one_hot   = $onehot(~samp_an);
  assign none_sel  = (samp_an == AN_IDLE);
  assign pos       = low_pos(samp_an);

  seg_pattern_to_bcd u_lookup (
    .cathode_i (samp_cath),
    .bcd_o     (bcd),
    .hit_o     (hit)
  );

  always_comb begin
    cnt_d    = '0;
    digits_d = digits_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_set  = 1'b0;

    if (stable) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    end

    if (accept) begin
      if (one_hot) begin
        if (hit) begin
          digits_d[{pos, 2'b00} +: 4] = bcd;
          valid_d[pos]                = 1'b1;
          update_d                    = 1'b1;
        end
`ifdef SEG_CAPTURE_BLANK_EN
        else if (samp_cath == SEG_BLANK) begin
          valid_d[pos] = 1'b0;
          update_d     = 1'b1;
        end
`endif
        else begin
          err_set = 1'b1;
        end
      end else if (!none_sel) begin
        err_set = 1'b1;
      end
    end

    err_d = err_set | (err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q   <= {AN_IDLE, CATH_IDLE};
      prev_q   <= {AN_IDLE, CATH_IDLE};
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      samp_q   <= {AN, cathode};
      prev_q   <= samp_q;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign err         = err_q;

endmodule
